output_accum_ctrl: RTL and testbench

Sequencer for the output accumulation block. After each compute pass it drains the N_COLS_ARRAY column results through the two-level output mux into the output BRAM. Each BRAM word is read, added and written back, so partial sums accumulate across input-channel passes. An optional clear pass first zeroes the target region through BRAM port B. It drives every registered control input of the output block except bram_rst_i.

---
 rtl/output_accum_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_output_accum_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_accum_ctrl.sv
// output_accum_ctrl: drain sequencer for the output accumulation block.
// After every compute pass it walks the column results through the
// two-level output mux and does a read-add-write into the output BRAM.
// A pass can optionally zero the target region through port B first.
// Optional build macro OUT_CTRL_SKIP_PAD_EN: when defined, mux positions
// beyond the last real column are skipped and never written.
module output_accum_ctrl #(
  parameter int N_COLS_ARRAY           = 3,
  parameter int NUMBER_MUX_OUT_1       = 1,
  parameter int NUMBER_INPUT_MUX_OUT_1 = (N_COLS_ARRAY + NUMBER_MUX_OUT_1 - 1) / NUMBER_MUX_OUT_1,
  parameter int SEL_WIDTH_MUX_OUT_1    = $clog2(1 + NUMBER_INPUT_MUX_OUT_1),
  parameter int SEL_WIDTH_MUX_OUT_2    = (NUMBER_MUX_OUT_1 > 1) ? $clog2(NUMBER_MUX_OUT_1) : 1,
  parameter int BRAM_ADDR_WIDTH        = 11
) (
  input  logic                           clk_i,
  input  logic                           bram_wr_en_a_rst_i,
  input  logic                           start_i,
  input  logic                           clear_i,
  input  logic [BRAM_ADDR_WIDTH-1:0]     base_addr_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [SEL_WIDTH_MUX_OUT_1-1:0] sel_mux_out_1_o,
  output logic [SEL_WIDTH_MUX_OUT_2-1:0] sel_mux_out_2_o,
  output logic                           sel_mux_ld_o,
  output logic                           sel_mux_rst_o,
  output logic                           reg_wr_en_o,
  output logic                           reg_rst_o,
  output logic                           bram_wr_en_a_o,
  output logic                           bram_wr_en_a_ld_o,
  output logic                           bram_wr_en_b_o,
  output logic                           bram_wr_en_b_ld_o,
  output logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_a_o,
  output logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_b_o
);

  localparam int NIN = NUMBER_INPUT_MUX_OUT_1;
  localparam int CW  = $clog2(N_COLS_ARRAY + 1);
  localparam int AW  = BRAM_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD0, LOAD1, ACC0, ACC1, DONE} state_t;

  state_t                         state, state_n;
  logic [SEL_WIDTH_MUX_OUT_1-1:0] k, k_n;
  logic [SEL_WIDTH_MUX_OUT_2-1:0] g, g_n;
  logic [CW-1:0]                  c, c_n;
  logic [AW-1:0]                  base, base_n;
  logic                           has_next_g;
  logic [31:0]                    idx_n;
  logic [AW-1:0]                  acc_addr_n, clr_addr_n;

  logic                           busy_n, done_n, sel_ld_n, reg_wr_n;
  logic                           we_a_n, we_a_ld_n, we_b_n, we_b_ld_n;
  logic [SEL_WIDTH_MUX_OUT_1-1:0] sel1_n;
  logic [SEL_WIDTH_MUX_OUT_2-1:0] sel2_n;
  logic [AW-1:0]                  addr_a_n, addr_b_n;

`ifdef OUT_CTRL_SKIP_PAD_EN
  logic [31:0] next_idx;
`endif

  // Next state, pass counters and the next value of every registered output
  always_comb begin
    state_n = state;
    k_n     = k;
    g_n     = g;
    c_n     = c;
    base_n  = base;

`ifdef OUT_CTRL_SKIP_PAD_EN
    next_idx   = (32'(g) + 32'd1) * 32'(NIN) + 32'(k) - 32'd1;
    has_next_g = (32'(g) + 32'd1 < 32'(NUMBER_MUX_OUT_1)) && (next_idx < 32'(N_COLS_ARRAY));
`else
    has_next_g = (32'(g) + 32'd1 < 32'(NUMBER_MUX_OUT_1));
`endif

    case (state)
      IDLE: begin
        if (start_i) begin
          base_n  = base_addr_i;
          k_n     = SEL_WIDTH_MUX_OUT_1'(1);
          g_n     = '0;
          c_n     = '0;
          state_n = clear_i ? CLEAR : LOAD0;
        end
      end
      CLEAR: begin
        if (c == CW'(N_COLS_ARRAY)) begin
          state_n = LOAD0;
        end else begin
          c_n = c + 1'b1;
        end
      end
      LOAD0: state_n = LOAD1;
      LOAD1: begin
        g_n     = '0;
        state_n = ACC0;
      end
      ACC0: state_n = ACC1;
      ACC1: begin
        if (has_next_g) begin
          g_n     = g + 1'b1;
          state_n = ACC0;
        end else if (32'(k) < 32'(NIN)) begin
          k_n     = k + 1'b1;
          g_n     = '0;
          state_n = LOAD0;
        end else begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    idx_n      = 32'(g_n) * 32'(NIN) + 32'(k_n) - 32'd1;
    acc_addr_n = AW'(32'(base_n) + idx_n);
    clr_addr_n = base_n + AW'(c_n);

    busy_n    = (state_n != IDLE) && (state_n != DONE);
    done_n    = 1'b0;
    sel1_n    = '0;
    sel2_n    = '0;
    sel_ld_n  = 1'b0;
    reg_wr_n  = 1'b0;
    we_a_n    = 1'b0;
    we_a_ld_n = 1'b0;
    we_b_n    = 1'b0;
    we_b_ld_n = 1'b0;
    addr_a_n  = '0;
    addr_b_n  = '0;

    case (state_n)
      CLEAR: begin
        addr_b_n  = clr_addr_n;
        we_b_n    = (c_n != CW'(N_COLS_ARRAY));
        we_b_ld_n = 1'b1;
      end
      LOAD0: begin
        sel1_n   = k_n;
        sel_ld_n = 1'b1;
      end
      LOAD1: begin
        sel1_n   = k_n;
        reg_wr_n = 1'b1;
      end
      ACC0: begin
        sel1_n    = k_n;
        sel2_n    = g_n;
        sel_ld_n  = 1'b1;
        addr_b_n  = acc_addr_n;
        we_a_n    = 1'b1;
        we_a_ld_n = 1'b1;
      end
      ACC1: begin
        sel1_n    = k_n;
        sel2_n    = g_n;
        addr_a_n  = acc_addr_n;
        addr_b_n  = acc_addr_n;
        we_a_ld_n = 1'b1;
      end
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

  // State, counters and all outputs registered; reset pulses the block resets once
  always_ff @(posedge clk_i or posedge bram_wr_en_a_rst_i) begin
    if (bram_wr_en_a_rst_i) begin
      state             <= IDLE;
      k                 <= '0;
      g                 <= '0;
      c                 <= '0;
      base              <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      sel_mux_out_1_o   <= '0;
      sel_mux_out_2_o   <= '0;
      sel_mux_ld_o      <= 1'b0;
      sel_mux_rst_o     <= 1'b1;
      reg_wr_en_o       <= 1'b0;
      reg_rst_o         <= 1'b1;
      bram_wr_en_a_o    <= 1'b0;
      bram_wr_en_a_ld_o <= 1'b0;
      bram_wr_en_b_o    <= 1'b0;
      bram_wr_en_b_ld_o <= 1'b0;
      bram_addr_a_o     <= '0;
      bram_addr_b_o     <= '0;
    end else begin
      state             <= state_n;
      k                 <= k_n;
      g                 <= g_n;
      c                 <= c_n;
      base              <= base_n;
      busy_o            <= busy_n;
      done_o            <= done_n;
      sel_mux_out_1_o   <= sel1_n;
      sel_mux_out_2_o   <= sel2_n;
      sel_mux_ld_o      <= sel_ld_n;
      sel_mux_rst_o     <= 1'b0;
      reg_wr_en_o       <= reg_wr_n;
      reg_rst_o         <= 1'b0;
      bram_wr_en_a_o    <= we_a_n;
      bram_wr_en_a_ld_o <= we_a_ld_n;
      bram_wr_en_b_o    <= we_b_n;
      bram_wr_en_b_ld_o <= we_b_ld_n;
      bram_addr_a_o     <= addr_a_n;
      bram_addr_b_o     <= addr_b_n;
    end
  end

endmodule

// File: tb/tb_output_accum_ctrl.sv
// tb_output_accum_ctrl: scoreboard bench for output_accum_ctrl.
// Instance 0 uses the default geometry (3 columns, 1 group); instance 1 uses
// 5 columns in 2 groups. A small model of the output block and BRAM turns
// the control outputs into BRAM writes, which are checked against
// hand-computed expectations. Honours OUT_CTRL_SKIP_PAD_EN for instance 1.
module tb_output_accum_ctrl;

  localparam int AW = 11;

  typedef struct {
    int inst;
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start, clear_in;
  logic [1:0][AW-1:0] base_in;
  logic [1:0] busy, done, sel_ld, sel_rst, reg_wr, reg_rst, wea, wea_ld, web, web_ld;
  logic [1:0][1:0] sel1;
  logic [1:0] sel2;
  logic [1:0][AW-1:0] addr_a, addr_b;

  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];

  int mem [2][2048];
  int col [2][8];
  int greg [2][2];
  int rdata [2];
  int sel1r [2];
  int sel2r [2];
  logic wea_r [2];
  int rd_next, idx;

  always #5 clk = ~clk;

  output_accum_ctrl dut0 (
    .clk_i(clk), .bram_wr_en_a_rst_i(rst), .start_i(start[0]), .clear_i(clear_in[0]),
    .base_addr_i(base_in[0]), .busy_o(busy[0]), .done_o(done[0]),
    .sel_mux_out_1_o(sel1[0]), .sel_mux_out_2_o(sel2[0:0]), .sel_mux_ld_o(sel_ld[0]),
    .sel_mux_rst_o(sel_rst[0]), .reg_wr_en_o(reg_wr[0]), .reg_rst_o(reg_rst[0]),
    .bram_wr_en_a_o(wea[0]), .bram_wr_en_a_ld_o(wea_ld[0]),
    .bram_wr_en_b_o(web[0]), .bram_wr_en_b_ld_o(web_ld[0]),
    .bram_addr_a_o(addr_a[0]), .bram_addr_b_o(addr_b[0])
  );

  output_accum_ctrl #(.N_COLS_ARRAY(5), .NUMBER_MUX_OUT_1(2)) dut1 (
    .clk_i(clk), .bram_wr_en_a_rst_i(rst), .start_i(start[1]), .clear_i(clear_in[1]),
    .base_addr_i(base_in[1]), .busy_o(busy[1]), .done_o(done[1]),
    .sel_mux_out_1_o(sel1[1]), .sel_mux_out_2_o(sel2[1:1]), .sel_mux_ld_o(sel_ld[1]),
    .sel_mux_rst_o(sel_rst[1]), .reg_wr_en_o(reg_wr[1]), .reg_rst_o(reg_rst[1]),
    .bram_wr_en_a_o(wea[1]), .bram_wr_en_a_ld_o(wea_ld[1]),
    .bram_wr_en_b_o(web[1]), .bram_wr_en_b_ld_o(web_ld[1]),
    .bram_addr_a_o(addr_a[1]), .bram_addr_b_o(addr_b[1])
  );

  function automatic int ncols(input int i);
    return (i == 0) ? 3 : 5;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic push_exp(input int inst, input int addr, input int data);
    wr_t e;
    e.inst = inst;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic record_write(input int inst, input int addr, input int data);
    wr_t e;
    mem[inst][addr] = data;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_write inst=%0d addr=0x%03h data=%0d expected none", inst, addr, data);
    end else begin
      e = exp_q.pop_front();
      checkOutput("wr_inst", inst, e.inst);
      checkOutput("wr_addr", addr, e.addr);
      checkOutput("wr_data", data, e.data);
    end
  endtask

  // Output block + BRAM model, evaluated mid-cycle on what the controller drives
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) wea_r[i] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rd_next = mem[i][addr_b[i]];
        if (wea_r[i]) record_write(i, int'(addr_a[i]), rdata[i] + greg[i][sel2r[i]]);
        if (web[i] && web_ld[i]) record_write(i, int'(addr_b[i]), 0);
        if (reg_wr[i]) begin
          for (int gi = 0; gi < 2; gi++) begin
            idx = gi * 3 + sel1r[i] - 1;
            if (sel1r[i] != 0 && idx < ncols(i)) greg[i][gi] = col[i][idx];
            else greg[i][gi] = 0;
          end
        end
        if (sel_ld[i]) begin
          sel1r[i] = int'(sel1[i]);
          sel2r[i] = int'(sel2[i]);
        end
        if (wea_ld[i]) wea_r[i] = wea[i];
        rdata[i] = rd_next;
      end
    end
  end

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_busy", int'(busy[i]), 0);
      checkOutput("rst_done", int'(done[i]), 0);
      checkOutput("rst_wea", int'(wea[i]), 0);
      checkOutput("rst_web", int'(web[i]), 0);
      checkOutput("rst_addr_a", int'(addr_a[i]), 0);
    end
    rst = 1'b0;
    #1;
    checkOutput("rel_sel_rst_hi", int'(sel_rst), 3);
    checkOutput("rel_reg_rst_hi", int'(reg_rst), 3);
    @(posedge clk);
    #1;
    checkOutput("rel_sel_rst_lo", int'(sel_rst), 0);
    checkOutput("rel_reg_rst_lo", int'(reg_rst), 0);
    checkOutput("rel_busy", int'(busy), 0);
  endtask

  task automatic applyStimulus(input int inst, input logic clr, input int base,
                               input int exp_lat, input logic restart);
    int n;
    int extra;
    @(negedge clk);
    start[inst] = 1'b1;
    clear_in[inst] = clr;
    base_in[inst] = AW'(base);
    @(posedge clk);
    #1;
    start[inst] = 1'b0;
    clear_in[inst] = 1'b0;
    base_in[inst] = AW'(base + 11'h155);
    checkOutput("busy_after_start", int'(busy[inst]), 1);
    n = 1;
    while (n < 300 && !done[inst]) begin
      start[inst] = (restart && n == 4);
      @(posedge clk);
      #1;
      n++;
    end
    start[inst] = 1'b0;
    checkOutput("done_latency", n, exp_lat);
    checkOutput("busy_at_done", int'(busy[inst]), 0);
    extra = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done[inst]) extra++;
    end
    checkOutput("done_single", extra, 0);
    checkOutput("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = '0;
    clear_in = '0;
    base_in = '0;
    for (int i = 0; i < 2; i++) begin
      wea_r[i] = 1'b0;
      sel1r[i] = 0;
      sel2r[i] = 0;
      rdata[i] = 0;
    end
    mem[0][16] = 1;
    mem[0][17] = 1;
    mem[0][18] = 1;
    col[0][0] = 5;
    col[0][1] = -3;
    col[0][2] = 7;
    for (int j = 0; j < 5; j++) col[1][j] = j + 1;

    reset_dut();

    // accumulate onto {1,1,1}
    push_exp(0, 16, 6);
    push_exp(0, 17, -2);
    push_exp(0, 18, 8);
    applyStimulus(0, 1'b0, 16, 13, 1'b0);

    // clear first, then accumulate
    push_exp(0, 16, 0);
    push_exp(0, 17, 0);
    push_exp(0, 18, 0);
    push_exp(0, 16, 5);
    push_exp(0, 17, -3);
    push_exp(0, 18, 7);
    applyStimulus(0, 1'b1, 16, 17, 1'b0);

    // second start while busy is ignored
    push_exp(0, 16, 10);
    push_exp(0, 17, -6);
    push_exp(0, 18, 14);
    applyStimulus(0, 1'b0, 16, 13, 1'b1);

    // reset while in ACC0
    @(negedge clk);
    start[0] = 1'b1;
    base_in[0] = AW'(64);
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    n = 0;
    while (!wea[0] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("reach_acc0", int'(wea[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_wea", int'(wea[0]), 0);
    checkOutput("midrst_busy", int'(busy[0]), 0);
    reset_dut();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midrst_idle", int'(busy[0]), 0);

    // wrapping addresses, two groups
    push_exp(1, 'h7FE, 1);
    push_exp(1, 'h001, 4);
    push_exp(1, 'h7FF, 2);
    push_exp(1, 'h002, 5);
    push_exp(1, 'h000, 3);
`ifdef OUT_CTRL_SKIP_PAD_EN
    applyStimulus(1, 1'b0, 'h7FE, 17, 1'b0);
`else
    push_exp(1, 'h003, 0);
    applyStimulus(1, 1'b0, 'h7FE, 19, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
